mux4x1_registered: RTL and testbench

- Parameterised 4-to-1 multiplexer: two select bits (s1, s0) choose one of four data inputs i0..i3.
- Provides a zero-latency combinational output `out` and a registered copy `out_q` with a valid flag.
- Used as a leaf data-steering element wherever a datapath needs either a glitch-free registered selection or an immediate combinational one.

---
 rtl/mux4_pkg.sv | 12 +
 rtl/mux4_comb.sv | 31 +++
 rtl/mux4x1_registered.sv | 60 ++++++
 tb/tb_mux4x1_registered.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mux4_pkg.sv
// Shared definitions for the 4:1 multiplexer family.
// Provides the select-code type and the symbolic select codes.
package mux4_pkg;

   typedef logic [1:0] sel_t;

   localparam sel_t SEL_I0 = 2'b00;
   localparam sel_t SEL_I1 = 2'b01;
   localparam sel_t SEL_I2 = 2'b10;
   localparam sel_t SEL_I3 = 2'b11;

endpackage

// File: rtl/mux4_comb.sv
// Pure combinational 4:1 select.
// Ports:
//   sel          select code {s1,s0}
//   i0..i3       WIDTH-bit data inputs
//   y            selected data, zero latency
module mux4_comb
   import mux4_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  sel_t             sel,
   input  logic [WIDTH-1:0] i0,
   input  logic [WIDTH-1:0] i1,
   input  logic [WIDTH-1:0] i2,
   input  logic [WIDTH-1:0] i3,
   output logic [WIDTH-1:0] y
);

   always_comb begin
      y = i0;
      case (sel)
         SEL_I0:  y = i0;
         SEL_I1:  y = i1;
         SEL_I2:  y = i2;
         SEL_I3:  y = i3;
         // An unknown select must not silently masquerade as i0.
         default: y = {WIDTH{1'bx}};
      endcase
   end

endmodule

// File: rtl/mux4x1_registered.sv
// 4:1 multiplexer with a combinational output and a registered copy.
// Ports:
//   clk, rst     clock; asynchronous active-high reset of the register stage
//   i0..i3       WIDTH-bit data inputs, chosen by {s1,s0}
//   s1, s0       select MSB / LSB
//   in_valid     capture strobe for the registered path
//   out          combinational selection (unaffected by rst)
//   out_q        selection captured on the previous in_valid cycle
//   out_valid    out_q was captured on the previous cycle
module mux4x1_registered
   import mux4_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i0,
   input  logic [WIDTH-1:0] i1,
   input  logic [WIDTH-1:0] i2,
   input  logic [WIDTH-1:0] i3,
   input  logic             s1,
   input  logic             s0,
   input  logic             in_valid,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] out_q,
   output logic             out_valid
);

   sel_t             sel_p0;
   logic [WIDTH-1:0] data_p1;
   logic             vld_p1;

   assign sel_p0 = {s1, s0};

   mux4_comb #(.WIDTH(WIDTH)) u_comb (
      .sel (sel_p0),
      .i0  (i0),
      .i1  (i1),
      .i2  (i2),
      .i3  (i3),
      .y   (out)
   );

   // Stage p0 -> p1: capture the selection on in_valid; data holds otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_p1 <= '0;
         vld_p1  <= 1'b0;
      end else begin
         vld_p1 <= in_valid;
         if (in_valid) begin
            data_p1 <= out;
         end
      end
   end

   assign out_q     = data_p1;
   assign out_valid = vld_p1;

endmodule

// File: tb/tb_mux4x1_registered.sv
module tb_mux4x1_registered;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] i0, i1, i2, i3;
   logic       s1, s0, in_valid;
   logic [7:0] out, out_q;
   logic       out_valid;

   logic       w_i0, w_i1, w_i2, w_i3, w_s1, w_s0, w_in_valid;
   logic       w_out, w_out_q, w_out_valid;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mux4x1_registered #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .i0(i0), .i1(i1), .i2(i2), .i3(i3),
      .s1(s1), .s0(s0), .in_valid(in_valid),
      .out(out), .out_q(out_q), .out_valid(out_valid)
   );

   mux4x1_registered #(.WIDTH(1)) dut_w1 (
      .clk(clk), .rst(rst), .i0(w_i0), .i1(w_i1), .i2(w_i2), .i3(w_i3),
      .s1(w_s1), .s0(w_s0), .in_valid(w_in_valid),
      .out(w_out), .out_q(w_out_q), .out_valid(w_out_valid)
   );

   typedef struct {
      logic [1:0] sel;
      logic [7:0] a0, a1, a2, a3;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Step to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] sel, input logic [7:0] a0, a1, a2, a3);
      s1 = sel[1]; s0 = sel[0];
      i0 = a0; i1 = a1; i2 = a2; i3 = a3;
   endtask

   // Reference: the selected input is simply the one indexed by the select code.
   function automatic logic [7:0] ref_sel(input logic [1:0] sel, input logic [7:0] a0, a1, a2, a3);
      logic [7:0] arr [4];
      arr[0] = a0; arr[1] = a1; arr[2] = a2; arr[3] = a3;
      return arr[sel];
   endfunction

   initial begin
      logic [5:0] c;
      logic [3:0] ins;
      logic [7:0] exp_q;
      logic       exp_v;
      logic [1:0] rs;
      logic [7:0] r0, r1, r2, r3;
      logic       rv, rr;

      rst = 1'b1; in_valid = 1'b0; w_in_valid = 1'b0;
      drive(2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
      w_s1 = 0; w_s0 = 0; w_i0 = 0; w_i1 = 0; w_i2 = 0; w_i3 = 0;
      #2;
      check("reset_out_q",      64'(out_q), 64'h0);
      check("reset_out_valid",  64'(out_valid), 64'h0);
      check("reset_w1_out_q",   64'(w_out_q), 64'h0);
      check("reset_w1_valid",   64'(w_out_valid), 64'h0);

      // Exhaustive WIDTH=1 sweep over {s1,s0,i0,i1,i2,i3}.
      for (int k = 0; k < 64; k++) begin
         c = 6'(k);
         {w_s1, w_s0, w_i0, w_i1, w_i2, w_i3} = c;
         ins = {w_i3, w_i2, w_i1, w_i0};
         #100;
         check("w1_exhaustive", 64'(w_out), 64'(ins[{w_s1, w_s0}]));
      end

      // Isolation table.
      vecs[0] = '{2'b00, 8'hA5, 8'h3C, 8'hF0, 8'h0F, 8'hA5};
      vecs[1] = '{2'b01, 8'hA5, 8'h3C, 8'hF0, 8'h0F, 8'h3C};
      vecs[2] = '{2'b10, 8'hA5, 8'h3C, 8'hF0, 8'h0F, 8'hF0};
      vecs[3] = '{2'b11, 8'hA5, 8'h3C, 8'hF0, 8'h0F, 8'h0F};
      vecs[4] = '{2'b00, 8'hA5, 8'hC3, 8'h0F, 8'hF0, 8'hA5};
      vecs[5] = '{2'b01, 8'h5A, 8'h3C, 8'h0F, 8'hF0, 8'h3C};
      vecs[6] = '{2'b10, 8'h5A, 8'hC3, 8'hF0, 8'hF0, 8'hF0};
      vecs[7] = '{2'b11, 8'h5A, 8'hC3, 8'h0F, 8'h0F, 8'h0F};
      for (int k = 0; k < 8; k++) begin
         drive(vecs[k].sel, vecs[k].a0, vecs[k].a1, vecs[k].a2, vecs[k].a3);
         #3;
         check("isolation", 64'(out), 64'(vecs[k].exp));
      end

      // Out tracks inputs while rst is still high; register stays clear.
      tick();
      check("rst_hold_out_q", 64'(out_q), 64'h0);

      rst = 1'b0;
      tick();

      // Registered latency.
      drive(2'b10, 8'hA5, 8'h3C, 8'h5A, 8'h0F);
      in_valid = 1'b1;
      tick();
      check("lat_out_q", 64'(out_q), 64'h5A);
      check("lat_valid", 64'(out_valid), 64'h1);
      in_valid = 1'b0;
      drive(2'b00, 8'h11, 8'h22, 8'h33, 8'h44);
      tick();
      check("lat_hold_valid", 64'(out_valid), 64'h0);
      check("lat_hold_out_q", 64'(out_q), 64'h5A);

      // Streaming four back-to-back captures.
      in_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         drive(vecs[k].sel, vecs[k].a0, vecs[k].a1, vecs[k].a2, vecs[k].a3);
         tick();
         check("stream_out_q", 64'(out_q), 64'(vecs[k].exp));
         check("stream_valid", 64'(out_valid), 64'h1);
      end

      // Async reset mid-stream while out_q holds 3C.
      drive(2'b01, 8'hA5, 8'h3C, 8'hF0, 8'h0F);
      tick();
      check("pre_rst_out_q", 64'(out_q), 64'h3C);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_out_q", 64'(out_q), 64'h0);
      check("async_rst_valid", 64'(out_valid), 64'h0);
      drive(2'b10, 8'hA5, 8'h3C, 8'hF0, 8'h0F);
      #1;
      check("rst_out_tracks", 64'(out), 64'hF0);
      tick();
      check("rst_edge_valid", 64'(out_valid), 64'h0);
      check("rst_edge_out_q", 64'(out_q), 64'h0);

      // Release with a capture pending.
      drive(2'b11, 8'hA5, 8'h3C, 8'hF0, 8'h0F);
      in_valid = 1'b1;
      rst = 1'b0;
      tick();
      check("release_out_q", 64'(out_q), 64'h0F);
      check("release_valid", 64'(out_valid), 64'h1);

      // Randomized run against the reference model.
      exp_q = 8'h0F; exp_v = 1'b1;
      for (int n = 0; n < 400; n++) begin
         rs = 2'($urandom_range(0, 3));
         r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom); r3 = 8'($urandom);
         rv = ($urandom_range(0, 3) != 0);
         rr = ($urandom_range(0, 15) == 0);
         drive(rs, r0, r1, r2, r3);
         in_valid = rv;
         #1;
         check("rand_out", 64'(out), 64'(ref_sel(rs, r0, r1, r2, r3)));
         if (rr) begin
            rst = 1'b1;
            #1;
            check("rand_async_rst", 64'({out_valid, out_q}), 64'h0);
            exp_q = 8'h00; exp_v = 1'b0;
         end else begin
            if (rv) exp_q = ref_sel(rs, r0, r1, r2, r3);
            exp_v = rv;
         end
         tick();
         check("rand_out_q", 64'(out_q), 64'(exp_q));
         check("rand_valid", 64'(out_valid), 64'(exp_v));
         rst = 1'b0;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
